// File: rtl/sync_count_checker.sv
// Self-checking monitor for a 4-bit synchronous counter. Locks onto a clean
// +1 mod 16 sequence, then counts wrap-arounds and flags/counts/snapshots
// sequence errors. All outputs are registered.
module sync_count_checker #(
   parameter int SYNC_LEN = 4,  // correct increments needed to lock (1..15)
   parameter int WRAP_W   = 8,  // wrap counter width (modular)
   parameter int ERR_W    = 8   // error counter width (saturating)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Q1,
   input  logic              Q2,
   input  logic              Q3,
   input  logic              Q4,
   input  logic              clr,
   output logic              locked,
   output logic              err_pulse,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [ERR_W-1:0]  err_count,
   output logic              err_sticky,
   output logic [3:0]        first_exp,
   output logic [3:0]        first_got
);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_TRACK} state_t;

   state_t            r_state,      w_nxt_state;
   logic [3:0]        r_prev;
   logic [3:0]        r_run,        w_nxt_run;
   logic              r_err_pulse,  w_nxt_err_pulse;
   logic              r_wrap_pulse, w_nxt_wrap_pulse;
   logic [WRAP_W-1:0] r_wrap_cnt,   w_nxt_wrap_cnt;
   logic [ERR_W-1:0]  r_err_cnt,    w_nxt_err_cnt;
   logic              r_sticky,     w_nxt_sticky;
   logic [3:0]        r_first_exp,  w_nxt_first_exp;
   logic [3:0]        r_first_got,  w_nxt_first_got;

   logic [3:0]        w_cur;
   logic [3:0]        w_exp;
   logic              w_match;

   assign w_cur   = {Q4, Q3, Q2, Q1};
   assign w_exp   = r_prev + 4'd1;   // 4-bit wrap makes 15->0 legal
   assign w_match = (w_cur == w_exp);

   // State, sample history and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_prev       <= '0;
         r_run        <= '0;
         r_err_pulse  <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_wrap_cnt   <= '0;
         r_err_cnt    <= '0;
         r_sticky     <= 1'b0;
         r_first_exp  <= '0;
         r_first_got  <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_prev       <= w_cur;
         r_run        <= w_nxt_run;
         r_err_pulse  <= w_nxt_err_pulse;
         r_wrap_pulse <= w_nxt_wrap_pulse;
         r_wrap_cnt   <= w_nxt_wrap_cnt;
         r_err_cnt    <= w_nxt_err_cnt;
         r_sticky     <= w_nxt_sticky;
         r_first_exp  <= w_nxt_first_exp;
         r_first_got  <= w_nxt_first_got;
      end
   end

   // Next-state and statistics; clr is applied first so an event on the
   // same edge is recorded on top of the cleared values
   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_run        = r_run;
      w_nxt_err_pulse  = 1'b0;
      w_nxt_wrap_pulse = 1'b0;
      w_nxt_wrap_cnt   = clr ? '0 : r_wrap_cnt;
      w_nxt_err_cnt    = clr ? '0 : r_err_cnt;
      w_nxt_sticky     = clr ? 1'b0 : r_sticky;
      w_nxt_first_exp  = clr ? 4'd0 : r_first_exp;
      w_nxt_first_got  = clr ? 4'd0 : r_first_got;
      case (r_state)
         S_IDLE: begin
            // first sample after reset only seeds the history
            w_nxt_state = S_SYNC;
            w_nxt_run   = '0;
         end
         S_SYNC: begin
            if (w_match) begin
               if (r_run == 4'(SYNC_LEN - 1)) begin
                  w_nxt_state = S_TRACK;
                  w_nxt_run   = '0;
               end else begin
                  w_nxt_run = r_run + 4'd1;
               end
            end else begin
               w_nxt_run = '0;
            end
         end
         S_TRACK: begin
            if (w_match) begin
               if (r_prev == 4'd15) begin
                  w_nxt_wrap_pulse = 1'b1;
                  w_nxt_wrap_cnt   = w_nxt_wrap_cnt + 1'b1;
               end
            end else begin
               w_nxt_err_pulse = 1'b1;
               if (w_nxt_err_cnt != '1)
                  w_nxt_err_cnt = w_nxt_err_cnt + 1'b1;
               if (!w_nxt_sticky) begin
                  w_nxt_sticky    = 1'b1;
                  w_nxt_first_exp = w_exp;
                  w_nxt_first_got = w_cur;
               end
               w_nxt_state = S_SYNC;
               w_nxt_run   = '0;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_run   = '0;
         end
      endcase
   end

   assign locked     = (r_state == S_TRACK);
   assign err_pulse  = r_err_pulse;
   assign wrap_pulse = r_wrap_pulse;
   assign wrap_count = r_wrap_cnt;
   assign err_count  = r_err_cnt;
   assign err_sticky = r_sticky;
   assign first_exp  = r_first_exp;
   assign first_got  = r_first_got;

endmodule

// File: tb/tb_sync_count_checker.sv
// Bench for sync_count_checker: directed scenarios plus a randomized run,
// all compared against a rule-level model of the checker.
module tb_sync_count_checker;

   localparam int SYNC_LEN = 4;
   localparam int WRAP_W   = 4;
   localparam int ERR_W    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              Q1 = 1'b0, Q2 = 1'b0, Q3 = 1'b0, Q4 = 1'b0;
   logic              clr = 1'b0;
   logic              locked, err_pulse, wrap_pulse, err_sticky;
   logic [WRAP_W-1:0] wrap_count;
   logic [ERR_W-1:0]  err_count;
   logic [3:0]        first_exp, first_got;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_started;
   int m_prev, m_streak, m_lock, m_ep, m_wp, m_wc, m_ec, m_sticky, m_fe, m_fg;

   sync_count_checker #(.SYNC_LEN(SYNC_LEN), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .clr(clr),
      .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
      .wrap_count(wrap_count), .err_count(err_count), .err_sticky(err_sticky),
      .first_exp(first_exp), .first_got(first_got));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".locked"},     int'(locked),     m_lock);
      check({tag, ".err_pulse"},  int'(err_pulse),  m_ep);
      check({tag, ".wrap_pulse"}, int'(wrap_pulse), m_wp);
      check({tag, ".wrap_count"}, int'(wrap_count), m_wc);
      check({tag, ".err_count"},  int'(err_count),  m_ec);
      check({tag, ".err_sticky"}, int'(err_sticky), m_sticky);
      check({tag, ".first_exp"},  int'(first_exp),  m_fe);
      check({tag, ".first_got"},  int'(first_got),  m_fg);
   endtask

   task automatic model_reset();
      m_started = 0; m_prev = 0; m_streak = 0; m_lock = 0; m_ep = 0; m_wp = 0;
      m_wc = 0; m_ec = 0; m_sticky = 0; m_fe = 0; m_fg = 0;
   endtask

   // Rule-level model: a sample is "good" if it is previous+1 mod 16.
   task automatic model_sample(input int cur, input bit c);
      int e;
      m_ep = 0; m_wp = 0;
      if (c) begin m_wc = 0; m_ec = 0; m_sticky = 0; m_fe = 0; m_fg = 0; end
      if (!m_started) begin
         m_started = 1; m_streak = 0;
      end else begin
         e = (m_prev + 1) % 16;
         if (m_lock != 0) begin
            if (cur == e) begin
               if (cur == 0) begin m_wp = 1; m_wc = (m_wc + 1) % (1 << WRAP_W); end
            end else begin
               m_ep = 1;
               m_ec = (m_ec + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_ec + 1;
               if (m_sticky == 0) begin m_sticky = 1; m_fe = e; m_fg = cur; end
               m_lock = 0; m_streak = 0;
            end
         end else if (cur == e) begin
            m_streak++;
            if (m_streak == SYNC_LEN) begin m_lock = 1; m_streak = 0; end
         end else begin
            m_streak = 0;
         end
      end
      m_prev = cur;
   endtask

   // One sample: drive away from the edge, let the edge take it, check after
   task automatic step(input int v, input bit c, input string tag);
      logic [3:0] q;
      @(negedge clk);
      q = 4'(v);
      {Q4, Q3, Q2, Q1} = q;
      clr = c;
      @(posedge clk);
      model_sample(v, c);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clr = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int v;
      // reset state
      #1;
      model_reset();
      check_all("por");
      do_reset();

      // 1. lock on 0..4: locked high exactly after sample 4
      for (int i = 0; i <= 4; i++) step(i, 0, "lock");
      check("lock.at4", int'(locked), 1);

      // 2. wrap: 37 samples from 0, wraps at samples 17 and 33
      do_reset();
      for (int i = 0; i < 37; i++) step(i % 16, 0, "wrap");
      check("wrap.count", int'(wrap_count), 2);
      check("wrap.errs",  int'(err_count), 0);

      // 3. glitch after 7 in TRACK, then relock at 9
      do_reset();
      for (int i = 0; i <= 7; i++) step(i, 0, "pre");
      step(5, 0, "glitch");
      check("glitch.pulse", int'(err_pulse), 1);
      check("glitch.fexp",  int'(first_exp), 8);
      check("glitch.fgot",  int'(first_got), 5);
      step(6, 0, "post");
      check("glitch.pulse_off", int'(err_pulse), 0);
      for (int i = 7; i <= 10; i++) step(i, 0, "relock");

      // 4. mismatches while syncing are not errors
      do_reset();
      step(0, 0, "s"); step(1, 0, "s");
      for (int i = 5; i <= 9; i++) step(i, 0, "syncerr");
      check("syncerr.lock", int'(locked), 1);
      check("syncerr.ec",   int'(err_count), 0);

      // 5. saturation then clr together with an error
      do_reset();
      for (int i = 0; i <= 4; i++) step(i, 0, "sat0");
      v = 4;
      for (int k = 0; k < 10; k++) begin
         v = (v + 3) % 16;
         step(v, 0, "sat.err");
         for (int j = 0; j < SYNC_LEN; j++) begin v = (v + 1) % 16; step(v, 0, "sat.rl"); end
      end
      check("sat.ec", int'(err_count), 7);
      step((v + 9) % 16, 1, "clr_err");
      check("clr.ec", int'(err_count), 1);
      check("clr.sticky", int'(err_sticky), 1);
      // clr coincident with a wrap
      v = (v + 9) % 16;
      for (int j = 0; j < SYNC_LEN; j++) begin v = (v + 1) % 16; step(v, 0, "rl2"); end
      while (v != 15) begin v++; step(v, 0, "to15"); end
      step(0, 1, "clr_wrap");
      check("clrwrap.wc", int'(wrap_count), 1);

      // 6. async reset mid-cycle while locked with counts nonzero
      step(1, 0, "pre_ar");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 3; i <= 7; i++) step(i, 0, "ar_relock");
      check("ar.lock", int'(locked), 1);

      // randomized: mostly clean counting with glitches and clr
      do_reset();
      v = int'($urandom_range(0, 15));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) v = int'($urandom_range(0, 15));
         else v = (v + 1) % 16;
         step(v, ($urandom_range(0, 29) == 0), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
